piece_control: RTL and testbench

PIECE_CONTROL -- requirements
Module: piece_control

---
 rtl/piece_control.sv | 187 ++++++++++++++++++
 tb/tb_piece_control.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/piece_control.sv
// Active-piece controller: arbitrates moves and gravity, probes four candidate
// cells against the board, then commits, locks, or ends the game.
module piece_control #(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 20,
    parameter int SPAWN_X = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            key_left,
    input  logic            key_right,
    input  logic            key_rot,
    input  logic            key_drop,
    input  logic            tick,
    input  logic [2:0]      shape_sel,
    output logic [4:0]      cand_left,
    output logic [4:0]      cand_top,
    output logic [1:0]      cand_rot,
    input  logic [3:0][4:0] xpos,
    input  logic [3:0][4:0] ypos,
    output logic [4:0]      occ_x,
    output logic [4:0]      occ_y,
    input  logic            occ_hit,
    output logic [4:0]      left,
    output logic [4:0]      top,
    output logic [1:0]      rotation,
    output logic [2:0]      shape_id,
    output logic            alive,
    output logic            lock_valid,
    input  logic            lock_ack,
    output logic            game_over
);

    typedef enum logic [2:0] {
        S_IDLE, S_SPAWN, S_WAIT, S_PROBE, S_FINAL, S_RESOLVE, S_LOCK, S_OVER
    } state_t;

    typedef enum logic [2:0] {
        R_SPAWN, R_ROT, R_LEFT, R_RIGHT, R_DROP, R_TICK, R_GRAV
    } req_t;

    typedef struct packed {
        logic [4:0] left;
        logic [4:0] top;
        logic [1:0] rot;
    } pos_t;

    localparam logic [5:0] BW = 6'(BOARD_W);
    localparam logic [5:0] BH = 6'(BOARD_H);
    localparam logic [4:0] SX = 5'(SPAWN_X);

    state_t     state, state_nxt;
    req_t       req, acc_req;
    pos_t       pos, cand;
    logic [2:0] shape_r;
    logic [1:0] idx;
    logic       fail, pend, acc, oob;

    assign cand_left = cand.left;
    assign cand_top  = cand.top;
    assign cand_rot  = cand.rot;
    assign left      = pos.left;
    assign top       = pos.top;
    assign rotation  = pos.rot;
    assign shape_id  = shape_r;

    assign alive      = (state != S_IDLE) && (state != S_OVER);
    assign lock_valid = (state == S_LOCK);
    assign game_over  = (state == S_OVER);

    always_comb begin
        occ_x = xpos[0];
        occ_y = ypos[0];
        if (state == S_PROBE || state == S_FINAL) begin
            occ_x = xpos[idx];
            occ_y = ypos[idx];
        end
    end

    assign oob = ({1'b0, xpos[idx]} >= BW) || ({1'b0, ypos[idx]} >= BH);

    // Fixed-priority arbiter; deferred gravity always wins so it cannot starve.
    always_comb begin
        acc     = 1'b1;
        acc_req = R_TICK;
        if (pend)           acc_req = R_GRAV;
        else if (key_rot)   acc_req = R_ROT;
        else if (key_left)  acc_req = R_LEFT;
        else if (key_right) acc_req = R_RIGHT;
        else if (key_drop)  acc_req = R_DROP;
        else if (tick)      acc_req = R_TICK;
        else                acc     = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = S_SPAWN;
            S_SPAWN:   state_nxt = S_PROBE;
            S_WAIT:    if (acc) state_nxt = S_PROBE;
            S_PROBE:   if (idx == 2'd3) state_nxt = S_FINAL;
            S_FINAL:   state_nxt = S_RESOLVE;
            S_RESOLVE: begin
                if (!fail) begin
                    state_nxt = (req == R_DROP) ? S_PROBE : S_WAIT;
                end else begin
                    case (req)
                        R_SPAWN:                state_nxt = S_OVER;
                        R_TICK, R_DROP, R_GRAV: state_nxt = S_LOCK;
                        default:                state_nxt = S_WAIT;
                    endcase
                end
            end
            S_LOCK:    if (lock_ack) state_nxt = S_SPAWN;
            S_OVER:    state_nxt = S_OVER;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos     <= '0;
            cand    <= '0;
            shape_r <= '0;
            req     <= R_SPAWN;
            idx     <= '0;
            fail    <= 1'b0;
            pend    <= 1'b0;
        end else begin
            // Ticks that can't be served now are remembered as one gravity step.
            if (tick && (state == S_SPAWN || state == S_PROBE || state == S_FINAL ||
                         state == S_RESOLVE || state == S_LOCK))
                pend <= 1'b1;

            case (state)
                S_SPAWN: begin
                    shape_r <= shape_sel;
                    cand    <= '{left: SX, top: 5'd0, rot: 2'd0};
                    req     <= R_SPAWN;
                    idx     <= '0;
                    fail    <= 1'b0;
                end
                S_WAIT: begin
                    if (acc) begin
                        req  <= acc_req;
                        idx  <= '0;
                        fail <= 1'b0;
                        if (acc_req == R_GRAV) pend <= 1'b0;
                        cand <= pos;
                        case (acc_req)
                            R_ROT:   cand.rot  <= pos.rot + 2'd1;
                            R_LEFT:  cand.left <= pos.left - 5'd1;
                            R_RIGHT: cand.left <= pos.left + 5'd1;
                            default: cand.top  <= pos.top + 5'd1;
                        endcase
                    end
                end
                S_PROBE: begin
                    // occ_hit lags the probe address by one cycle, so idx 0 carries no result.
                    fail <= fail | oob | ((idx != 2'd0) & occ_hit);
                    if (idx != 2'd3) idx <= idx + 2'd1;
                end
                S_FINAL: fail <= fail | occ_hit;
                S_RESOLVE: begin
                    if (!fail) begin
                        pos <= cand;
                        if (req == R_DROP) begin
                            cand.top <= cand.top + 5'd1;
                            idx      <= '0;
                            fail     <= 1'b0;
                        end
                    end else begin
                        cand <= pos;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_piece_control.sv
// Directed bench for piece_control with a two-shape stage model and a
// registered board-occupancy model.
module tb_piece_control;

    logic            clk, rst_n;
    logic            start, key_left, key_right, key_rot, key_drop, tick;
    logic [2:0]      shape_sel;
    logic [4:0]      cand_left, cand_top;
    logic [1:0]      cand_rot;
    logic [3:0][4:0] xpos, ypos;
    logic [4:0]      occ_x, occ_y;
    logic            occ_hit;
    logic [4:0]      left, top;
    logic [1:0]      rotation;
    logic [2:0]      shape_id;
    logic            alive, lock_valid, lock_ack, game_over;

    logic [31:0] board [32];
    int n_chk, n_pass;

    piece_control dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .key_left(key_left), .key_right(key_right), .key_rot(key_rot),
        .key_drop(key_drop), .tick(tick), .shape_sel(shape_sel),
        .cand_left(cand_left), .cand_top(cand_top), .cand_rot(cand_rot),
        .xpos(xpos), .ypos(ypos), .occ_x(occ_x), .occ_y(occ_y),
        .occ_hit(occ_hit), .left(left), .top(top), .rotation(rotation),
        .shape_id(shape_id), .alive(alive), .lock_valid(lock_valid),
        .lock_ack(lock_ack), .game_over(game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shape 0: I piece (vertical on even rotations); every other shape: 2x2 O.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            if (shape_id == 3'd0) begin
                if (cand_rot[0] == 1'b0) begin
                    xpos[i] = cand_left;
                    ypos[i] = cand_top + 5'(i);
                end else begin
                    xpos[i] = cand_left + 5'(i);
                    ypos[i] = cand_top;
                end
            end else begin
                xpos[i] = cand_left + {4'b0, i[0]};
                ypos[i] = cand_top + {4'b0, i[1]};
            end
        end
    end

    initial occ_hit = 1'b0;
    always @(posedge clk) occ_hit <= board[occ_y][occ_x];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // keys = {rot, left, right, drop}; returns once the check has resolved into WAIT.
    task automatic press(input logic [3:0] keys);
        {key_rot, key_left, key_right, key_drop} = keys;
        cyc(1);
        {key_rot, key_left, key_right, key_drop} = 4'b0;
        cyc(6);
    endtask

    task automatic wait_lock();
        for (int i = 0; i < 400 && !lock_valid; i++) @(negedge clk);
        chk("lock_seen", lock_valid, 1);
    endtask

    task automatic ack_lock();
        lock_ack = 1'b1;
        cyc(1);
        lock_ack = 1'b0;
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        for (int i = 0; i < 32; i++) board[i] = '0;
        {start, key_left, key_right, key_rot, key_drop, tick, lock_ack} = '0;
        shape_sel = 3'd6;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        cyc(2);
        chk("rst_alive", alive, 0);
        chk("rst_left", left, 0);
        chk("rst_shape", shape_id, 0);
        chk("rst_lock", lock_valid, 0);
        chk("rst_over", game_over, 0);
        rst_n = 1'b1;
        cyc(1);

        // spawn shape 6 at (3,0)
        start = 1'b1; cyc(1); start = 1'b0;
        chk("spawn_alive_early", alive, 1);
        cyc(7);
        chk("spawn_left", left, 3);
        chk("spawn_top", top, 0);
        chk("spawn_rot", rotation, 0);
        chk("spawn_shape", shape_id, 6);

        // walk to the left wall, then bump it
        press(4'b0100); press(4'b0100); press(4'b0100);
        chk("wall_left", left, 0);
        press(4'b0100);
        chk("wrap_left", left, 0);
        chk("wrap_nolock", lock_valid, 0);
        chk("wrap_cand", cand_left, 0);
        press(4'b0010);
        chk("right_left", left, 1);

        // rot beats left in the same cycle
        press(4'b1100);
        chk("arb_rot", rotation, 1);
        chk("arb_left", left, 1);

        // tick during PROBE becomes pending gravity
        key_right = 1'b1; cyc(1); key_right = 1'b0;
        cyc(1); tick = 1'b1; cyc(1); tick = 1'b0;
        cyc(4);
        chk("pend_left", left, 2);
        chk("pend_top0", top, 0);
        cyc(7);
        chk("pend_top1", top, 1);

        // hard drop of the O piece to the floor
        key_drop = 1'b1; cyc(1); key_drop = 1'b0;
        wait_lock();
        chk("dropO_top", top, 18);
        key_left = 1'b1; cyc(1); key_left = 1'b0;
        cyc(2);
        chk("lock_hold", lock_valid, 1);
        chk("lock_left", left, 2);
        chk("lock_top", top, 18);

        shape_sel = 3'd0;
        ack_lock();
        chk("ack_clear", lock_valid, 0);
        cyc(7);
        chk("respawn_top", top, 0);
        chk("respawn_left", left, 3);
        chk("respawn_shape", shape_id, 0);

        // hard drop of the vertical I piece
        key_drop = 1'b1; cyc(1); key_drop = 1'b0;
        wait_lock();
        chk("dropI_top", top, 16);

        // blocked spawn cell ends the game
        board[0][3] = 1'b1;
        shape_sel = 3'd6;
        ack_lock();
        cyc(7);
        chk("over_flag", game_over, 1);
        chk("over_alive", alive, 0);
        chk("over_top", top, 16);
        start = 1'b1; tick = 1'b1; cyc(1); start = 1'b0; tick = 1'b0;
        cyc(8);
        chk("over_sticky", game_over, 1);

        rst_n = 1'b0;
        #1;
        chk("over_rst", game_over, 0);
        chk("over_rst_top", top, 0);
        cyc(1);
        rst_n = 1'b1;
        board[0][3] = 1'b0;
        cyc(1);

        // reset in the middle of a check
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(7);
        chk("s2_left", left, 3);
        key_right = 1'b1; cyc(1); key_right = 1'b0;
        cyc(1);
        rst_n = 1'b0;
        #1;
        chk("mid_alive", alive, 0);
        chk("mid_left", left, 0);
        chk("mid_cand", cand_left, 0);
        chk("mid_shape", shape_id, 6'd0);
        chk("mid_occx", occ_x, 0);
        cyc(1);
        rst_n = 1'b1;
        cyc(5);
        chk("idle_after", alive, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
